// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU in the execute stage.
// Holds the pipeline via div_stall and keeps hi/lo stable until the instruction leaves execute.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             stall_ext,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q, rneg_q, dvz_q;
    logic             accept, finish;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, diff;
    logic             fit;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Operand magnitudes; unsigned mode passes operands through untouched.
    always_comb begin
        abs_a = (signed_div && a[WIDTH-1]) ? WIDTH'(-a) : a;
        abs_b = (signed_div && b[WIDTH-1]) ? WIDTH'(-b) : b;
    end

    // One restoring shift-subtract step; dividend bits shift out of quo_q as quotient bits shift in.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        fit      = ~diff[WIDTH];
        rem_step = fit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // div_stall is derived before the flush override so it never depends on flush.
    always_comb begin
        state_nxt = state;
        div_stall = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                div_stall = start;
                if (start) begin
                    state_nxt = BUSY;
                    accept    = 1'b1;
                end
            end
            BUSY: begin
                div_stall = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (!stall_ext) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dvz_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            rem_q  <= '0;
            quo_q  <= abs_a;
            dvs_q  <= abs_b;
            cnt_q  <= CNT_W'(WIDTH);
            qneg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= signed_div & a[WIDTH-1];
            dvz_q  <= (b == '0);
        end else if (state == BUSY) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (finish) begin
                // A zero divisor leaves the dividend as remainder; only the quotient is forced.
                hi <= rneg_q ? WIDTH'(-rem_step) : rem_step;
                lo <= dvz_q ? '1 : (qneg_q ? WIDTH'(-quo_step) : quo_step);
            end
        end
    end

    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_ext;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .stall_ext    (stall_ext),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS semantics: truncating division, remainder takes the dividend's sign; x/0 fixed to {~0, x}.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Issue a divide, measure the stall length and check the result in DONE.
    // With release set, the instruction then advances and the idle state is checked.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                           input bit release_it);
        logic [31:0] eq, er;
        int stall_len;
        model(av, bv, sg, eq, er);
        @(negedge clk);
        start      = 1'b1;
        a          = av;
        b          = bv;
        signed_div = sg;
        #1;
        stall_len = 0;
        while (div_stall && stall_len < 100) begin
            stall_len++;
            @(negedge clk);
            #1;
        end
        check("stall_len", 32'(stall_len), 32'd33);
        check("done_valid", {31'd0, result_valid}, 32'd1);
        check("lo", lo, eq);
        check("hi", hi, er);
        if (release_it) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            #1;
            check("idle_valid", {31'd0, result_valid}, 32'd0);
            check("idle_stall", {31'd0, div_stall}, 32'd0);
            check("idle_lo_hold", lo, eq);
            check("idle_hi_hold", hi, er);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, hold_hi, hold_lo;
        logic        rs;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        flush = 1'b0; stall_ext = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Directed cases
        run_div(32'd100, 32'd7, 1'b0, 1'b1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_div(32'd5, 32'd0, 1'b0, 1'b1);
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);

        // Result hold under external stall with start still asserted
        run_div(32'd1000, 32'd33, 1'b0, 1'b0);
        stall_ext = 1'b1;
        hold_hi   = hi;
        hold_lo   = lo;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("hold_stall", {31'd0, div_stall}, 32'd0);
            check("hold_valid", {31'd0, result_valid}, 32'd1);
            check("hold_hi", hi, hold_hi);
            check("hold_lo", lo, hold_lo);
        end
        stall_ext = 1'b0;
        // Next divide enters right after leaving DONE
        run_div(32'hFFFF_FF00, 32'd3, 1'b1, 1'b1);

        // Flush in DONE
        run_div(32'd77, 32'd5, 1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        #1;
        check("flush_done_valid", {31'd0, result_valid}, 32'd0);
        check("flush_done_stall", {31'd0, div_stall}, 32'd0);

        // start and flush together in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd2; signed_div = 1'b0;
        #1;
        check("sf_stall_comb", {31'd0, div_stall}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        check("sf_stall_next", {31'd0, div_stall}, 32'd0);
        check("sf_valid", {31'd0, result_valid}, 32'd0);

        // Reset in the middle of BUSY
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        #1;
        check("mrst_stall", {31'd0, div_stall}, 32'd0);
        check("mrst_valid", {31'd0, result_valid}, 32'd0);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("mrst_late_valid", {31'd0, result_valid}, 32'd0);
        check("mrst_late_lo", lo, 32'd0);

        // Random divides
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: rb = $urandom;
            endcase
            run_div(ra, rb, rs, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
